// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg: shared datapath widths and the hardwired-zero register address.
package banco_registradores_pkg;
    localparam int LARGURA_PADRAO     = 8;
    localparam int NUM_REGS_PADRAO    = 8;
    localparam int LARGURA_END_PADRAO = $clog2(NUM_REGS_PADRAO);
    localparam int REG_ZERO           = 0;
endpackage

// File: rtl/banco_registradores_if.sv
// banco_registradores_if: write, operand and debug signals between the datapath and the register file.
interface banco_registradores_if
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA     = LARGURA_PADRAO,
    parameter int NUM_REGS    = NUM_REGS_PADRAO,
    parameter int LARGURA_END = LARGURA_END_PADRAO
);
    logic                   EscritaHabilitada;
    logic [LARGURA_END-1:0] EnderecoEscrita;
    logic [LARGURA-1:0]     DadoEscrita;
    logic [LARGURA_END-1:0] EnderecoLeitura1;
    logic [LARGURA_END-1:0] EnderecoLeitura2;
    logic [LARGURA_END-1:0] EnderecoDepuracao;
    logic [LARGURA-1:0]     DadoLeitura1;
    logic [LARGURA-1:0]     DadoLeitura2;
    logic [LARGURA-1:0]     DadoDepuracao;
    logic [NUM_REGS-1:0]    RegistrosEscritos;

    modport master (
        output EscritaHabilitada, EnderecoEscrita, DadoEscrita,
        output EnderecoLeitura1, EnderecoLeitura2, EnderecoDepuracao,
        input  DadoLeitura1, DadoLeitura2, DadoDepuracao, RegistrosEscritos
    );
    modport slave (
        input  EscritaHabilitada, EnderecoEscrita, DadoEscrita,
        input  EnderecoLeitura1, EnderecoLeitura2, EnderecoDepuracao,
        output DadoLeitura1, DadoLeitura2, DadoDepuracao, RegistrosEscritos
    );
endinterface

// File: rtl/banco_registradores_porta_leitura_bypass.sv
// porta_leitura_bypass: one operand read port with reg-0 forcing and same-cycle write forwarding.
module porta_leitura_bypass
    import banco_registradores_pkg::*;
#(
    parameter int LARGURA     = LARGURA_PADRAO,
    parameter int NUM_REGS    = NUM_REGS_PADRAO,
    parameter int LARGURA_END = LARGURA_END_PADRAO,
    parameter bit BYPASS      = 1'b1
) (
    input  logic [NUM_REGS-1:0][LARGURA-1:0] regs_i,
    input  logic [LARGURA_END-1:0]           endereco_i,
    input  logic                             escrita_i,
    input  logic [LARGURA_END-1:0]           endereco_escrita_i,
    input  logic [LARGURA-1:0]               dado_escrita_i,
    output logic [LARGURA-1:0]               dado_o
);
    logic [LARGURA-1:0] armazenado;
    logic               encaminha;

    // escrita_i is already qualified by reset and the non-zero destination
    assign armazenado = (endereco_i == LARGURA_END'(REG_ZERO)) ? '0 : regs_i[endereco_i];
    assign encaminha  = BYPASS && escrita_i && (endereco_i == endereco_escrita_i);
    assign dado_o     = encaminha ? dado_escrita_i : armazenado;
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 8x8 register file, reg 0 hardwired to zero, two bypassed read ports,
// an unbypassed debug port and a sticky per-register written bitmap.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int                LARGURA     = LARGURA_PADRAO,
    parameter int                NUM_REGS    = NUM_REGS_PADRAO,
    parameter int                LARGURA_END = $clog2(NUM_REGS),
    parameter bit                BYPASS      = 1'b1,
    parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
    input logic                 Clock,
    input logic                 Reset,
    banco_registradores_if.slave bus
);
    logic [NUM_REGS-1:0][LARGURA-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]              escritos_q, escritos_d;
    logic                             escrita, encaminha;

    assign escrita   = bus.EscritaHabilitada && (bus.EnderecoEscrita != LARGURA_END'(REG_ZERO));
    assign encaminha = escrita && !Reset;

    always_comb begin
        regs_d     = regs_q;
        escritos_d = escritos_q;
        if (escrita) begin
            regs_d[bus.EnderecoEscrita]     = bus.DadoEscrita;
            escritos_d[bus.EnderecoEscrita] = 1'b1;
        end
    end

    // reg 0 is only ever loaded at reset; the read paths force it to zero regardless
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? '0 : VALOR_RESET;
            escritos_q <= '0;
        end else begin
            regs_q     <= regs_d;
            escritos_q <= escritos_d;
        end
    end

    porta_leitura_bypass #(
        .LARGURA(LARGURA), .NUM_REGS(NUM_REGS), .LARGURA_END(LARGURA_END), .BYPASS(BYPASS)
    ) u_porta1 (
        .regs_i(regs_q), .endereco_i(bus.EnderecoLeitura1), .escrita_i(encaminha),
        .endereco_escrita_i(bus.EnderecoEscrita), .dado_escrita_i(bus.DadoEscrita),
        .dado_o(bus.DadoLeitura1)
    );

    porta_leitura_bypass #(
        .LARGURA(LARGURA), .NUM_REGS(NUM_REGS), .LARGURA_END(LARGURA_END), .BYPASS(BYPASS)
    ) u_porta2 (
        .regs_i(regs_q), .endereco_i(bus.EnderecoLeitura2), .escrita_i(encaminha),
        .endereco_escrita_i(bus.EnderecoEscrita), .dado_escrita_i(bus.DadoEscrita),
        .dado_o(bus.DadoLeitura2)
    );

    assign bus.DadoDepuracao     = (bus.EnderecoDepuracao == LARGURA_END'(REG_ZERO)) ? '0 : regs_q[bus.EnderecoDepuracao];
    assign bus.RegistrosEscritos = escritos_q;
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed vector table plus reset and write-back selector sequences.
module tb_banco_registradores;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_testes = 0;
    int   n_falhas = 0;

    banco_registradores_if bus ();

    banco_registradores #(.BYPASS(1'b1), .VALOR_RESET(8'h00)) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] dbg;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] edbg;
        logic [7:0] ebm;
    } vetor_t;

    vetor_t tabela [12];

    task automatic verifica(input string nome, input logic [7:0] atual, input logic [7:0] esperado);
        n_testes++;
        if (atual !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic aplica(input logic r, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                          input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] dbg);
        @(negedge clk);
        rst                   = r;
        bus.EscritaHabilitada = we;
        bus.EnderecoEscrita   = wa;
        bus.DadoEscrita       = wd;
        bus.EnderecoLeitura1  = r1;
        bus.EnderecoLeitura2  = r2;
        bus.EnderecoDepuracao = dbg;
        #1;
    endtask

    function automatic logic [7:0] seletor3(input logic [1:0] sel);
        return (sel == 2'b00) ? 8'hFF : (sel == 2'b01) ? 8'h55 : 8'h00;
    endfunction

    initial begin
        // rst we wa wd r1 r2 dbg | e1 e2 edbg bitmap ; checked before the edge that commits the row
        tabela[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00};
        tabela[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 3'd5, 8'h00, 8'h00, 8'h00, 8'h00};
        tabela[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        tabela[3]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 3'd3, 8'hA5, 8'h00, 8'h00, 8'h00};
        tabela[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'h08};
        tabela[5]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h08};
        tabela[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 3'd0, 8'h00, 8'hA5, 8'h00, 8'h08};
        tabela[7]  = '{1'b0, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h00, 8'h08};
        tabela[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 3'd5, 8'h3C, 8'hA5, 8'h3C, 8'h28};
        tabela[9]  = '{1'b0, 1'b1, 3'd6, 8'h77, 3'd6, 3'd5, 3'd6, 8'h77, 8'h3C, 8'h00, 8'h28};
        tabela[10] = '{1'b1, 1'b1, 3'd2, 8'h11, 3'd2, 3'd6, 3'd6, 8'h00, 8'h77, 8'h77, 8'h68};
        tabela[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd6, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00};

        aplica(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);

        for (int i = 0; i < 12; i++) begin
            aplica(tabela[i].rst, tabela[i].we, tabela[i].wa, tabela[i].wd,
                   tabela[i].r1, tabela[i].r2, tabela[i].dbg);
            verifica($sformatf("vec%0d DadoLeitura1", i), bus.DadoLeitura1, tabela[i].e1);
            verifica($sformatf("vec%0d DadoLeitura2", i), bus.DadoLeitura2, tabela[i].e2);
            verifica($sformatf("vec%0d DadoDepuracao", i), bus.DadoDepuracao, tabela[i].edbg);
            verifica($sformatf("vec%0d RegistrosEscritos", i), bus.RegistrosEscritos, tabela[i].ebm);
        end

        for (int k = 0; k < 3; k++) begin
            aplica(1'b0, 1'b1, 3'(k + 1), seletor3(2'(k)), 3'(k + 1), 3'(k + 1), 3'(k + 1));
            verifica($sformatf("sel%0d bypass1", k), bus.DadoLeitura1, seletor3(2'(k)));
            verifica($sformatf("sel%0d bypass2", k), bus.DadoLeitura2, seletor3(2'(k)));
        end
        aplica(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd3);
        verifica("sel reg1", bus.DadoLeitura1, 8'hFF);
        verifica("sel reg2", bus.DadoLeitura2, 8'h55);
        verifica("sel reg3", bus.DadoDepuracao, 8'h00);
        verifica("sel bitmap", bus.RegistrosEscritos, 8'h0E);

        aplica(1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd1);
        aplica(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 3'd1);
        verifica("reset2 reg1", bus.DadoLeitura1, 8'h00);
        verifica("reset2 dbg1", bus.DadoDepuracao, 8'h00);
        verifica("reset2 bitmap", bus.RegistrosEscritos, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_testes, n_falhas);
        $finish;
    end
endmodule
